// File: rtl/fetch_pkg.sv
// Shared encodings for the instruction-fetch stage.
package fetch_pkg;

    // Redirect target select from Decode; 2'b11 falls back to the branch target
    localparam logic [1:0] PCT_BRANCH = 2'b00;
    localparam logic [1:0] PCT_REG    = 2'b01;
    localparam logic [1:0] PCT_INDEX  = 2'b10;

    // Bubble instruction: addi x0,x0,0
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        S_REQ  = 2'b00,
        S_HOLD = 2'b01,
        S_KILL = 2'b10
    } fetch_state_t;

endpackage

// File: rtl/fetch_if.sv
// Instruction-memory request/response port between fetch and memory.
interface fetch_if;

    logic        if_mem_req;
    logic [31:0] if_mem_addr;
    logic        mem_if_ready;
    logic [31:0] mem_if_data;

    modport master (
        output if_mem_req,
        output if_mem_addr,
        input  mem_if_ready,
        input  mem_if_data
    );

    modport slave (
        input  if_mem_req,
        input  if_mem_addr,
        output mem_if_ready,
        output mem_if_data
    );

endinterface

// File: rtl/pc_target_mux.sv
// Redirect target select driven by Decode's selpctype.
module pc_target_mux
    import fetch_pkg::*;
(
    input  logic [1:0]  selpctype,
    input  logic [31:0] rega,
    input  logic [31:0] pcimd2ext,
    input  logic [31:0] pcindex,
    output logic [31:0] target
);

    // Pick the redirect target; the unused encoding behaves as a branch
    always_comb begin
        target = pcimd2ext;
        case (selpctype)
            PCT_BRANCH: target = pcimd2ext;
            PCT_REG:    target = rega;
            PCT_INDEX:  target = pcindex;
            default:    target = pcimd2ext;
        endcase
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, drives the memory port, feeds Decode.
//
// state  | meaning
// S_REQ  | requesting at pc; deliver fetched word or bubble each cycle
// S_HOLD | fetched word parked in buffer while Decode is stalled
// S_KILL | waiting out a response made stale by a redirect
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = fetch_pkg::NOP_INSTR
) (
    input  logic          clock,
    input  logic          reset,
    fetch_if.master       mem,
    input  logic          id_if_selpcsource,
    input  logic [1:0]    id_if_selpctype,
    input  logic [31:0]   id_if_rega,
    input  logic [31:0]   id_if_pcimd2ext,
    input  logic [31:0]   id_if_pcindex,
    input  logic          if_stall,
    output logic [31:0]   if_id_instruc,
    output logic [31:0]   if_id_nextpc
);
    import fetch_pkg::*;

    fetch_state_t state;
    logic [31:0]  pc;
    logic [31:0]  buffer;
    logic [31:0]  bufpc;
    logic [31:0]  pending;
    logic         req;

    logic [31:0]  target;
    logic [31:0]  pc_plus4;
    logic [31:0]  kill_target;
    logic         redirect;

    pc_target_mux u_target_mux (
        .selpctype (id_if_selpctype),
        .rega      (id_if_rega),
        .pcimd2ext (id_if_pcimd2ext),
        .pcindex   (id_if_pcindex),
        .target    (target)
    );

    // A stalled Decode re-issues its redirect later, so ignore it while stalled
    assign redirect    = id_if_selpcsource & ~if_stall;
    assign pc_plus4    = pc + 32'd4;
    assign kill_target = redirect ? target : pending;

    assign mem.if_mem_req  = req;
    assign mem.if_mem_addr = pc;

    // Fetch sequencing, PC update and Decode-side output registers
    always_ff @(posedge clock) begin
        if (!reset) begin
            state         <= S_REQ;
            pc            <= RESET_PC;
            req           <= 1'b0;
            buffer        <= 32'd0;
            bufpc         <= 32'd0;
            pending       <= 32'd0;
            if_id_instruc <= NOP_INSTR;
            if_id_nextpc  <= RESET_PC;
        end else begin
            case (state)
                S_REQ: begin
                    if (!req) begin
                        // First cycle out of reset: start requesting
                        req <= 1'b1;
                        if (!if_stall)
                            if_id_instruc <= NOP_INSTR;
                        if (redirect)
                            pc <= target;
                    end else if (mem.mem_if_ready) begin
                        if (if_stall) begin
                            buffer <= mem.mem_if_data;
                            bufpc  <= pc_plus4;
                            req    <= 1'b0;
                            state  <= S_HOLD;
                        end else begin
                            if_id_instruc <= mem.mem_if_data;
                            if_id_nextpc  <= pc_plus4;
                            pc            <= redirect ? target : pc_plus4;
                        end
                    end else if (redirect) begin
                        // Address must stay put, so remember where to go
                        pending       <= target;
                        if_id_instruc <= NOP_INSTR;
                        state         <= S_KILL;
                    end else if (!if_stall) begin
                        if_id_instruc <= NOP_INSTR;
                    end
                end
                S_HOLD: begin
                    if (!if_stall) begin
                        if_id_instruc <= buffer;
                        if_id_nextpc  <= bufpc;
                        pc            <= redirect ? target : bufpc;
                        req           <= 1'b1;
                        state         <= S_REQ;
                    end
                end
                S_KILL: begin
                    if (mem.mem_if_ready) begin
                        pc    <= kill_target;
                        state <= S_REQ;
                    end else if (redirect) begin
                        pending <= target;
                    end
                    if (!if_stall)
                        if_id_instruc <= NOP_INSTR;
                end
                default: begin
                    state <= S_REQ;
                    req   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with an expected-delivery scoreboard.
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct {
        logic [31:0] ins;
        logic [31:0] npc;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        sel   = 1'b0;
    logic [1:0]  ptype = 2'b00;
    logic [31:0] rega  = 32'd0;
    logic [31:0] pcimd = 32'd0;
    logic [31:0] pcidx = 32'd0;
    logic        stall = 1'b0;
    logic [31:0] instruc;
    logic [31:0] nextpc;

    // Memory model: zero-latency mode answers every request; otherwise rdy paces it.
    // The returned word is the request address itself.
    logic zl  = 1'b0;
    logic rdy = 1'b0;

    int   n_assert = 0;
    int   n_fail   = 0;
    exp_t sb[$];

    fetch_if mem ();

    assign mem.mem_if_ready = mem.if_mem_req & (zl | rdy);
    assign mem.mem_if_data  = mem.if_mem_addr;

    fetch_stage #(
        .RESET_PC  (32'h0000_0000),
        .NOP_INSTR (32'h0000_0013)
    ) dut (
        .clock             (clock),
        .reset             (reset),
        .mem               (mem),
        .id_if_selpcsource (sel),
        .id_if_selpctype   (ptype),
        .id_if_rega        (rega),
        .id_if_pcimd2ext   (pcimd),
        .id_if_pcindex     (pcidx),
        .if_stall          (stall),
        .if_id_instruc     (instruc),
        .if_id_nextpc      (nextpc)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic push(input logic [31:0] ins, input logic [31:0] npc);
        exp_t e;
        e.ins = ins;
        e.npc = npc;
        sb.push_back(e);
    endtask

    // One clock: protocol check on the address, then score the Decode outputs
    task automatic tick();
        logic        pend;
        logic [31:0] a;
        exp_t        e;
        @(negedge clock);
        pend = mem.if_mem_req && !mem.mem_if_ready && reset;
        a    = mem.if_mem_addr;
        @(posedge clock);
        #1;
        if (pend)
            chk("addr_stable", mem.if_mem_addr, a);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("instruc", instruc, e.ins);
            chk("nextpc", nextpc, e.npc);
        end
    endtask

    initial begin
        // Reset values
        tick();
        push(NOP, 32'h0); tick();
        chk("rst_req", {31'd0, mem.if_mem_req}, 32'd0);
        chk("rst_addr", mem.if_mem_addr, 32'h0);

        // Zero-latency streaming
        reset = 1'b1; zl = 1'b1;
        push(NOP, 32'h0); tick();
        chk("first_req", {31'd0, mem.if_mem_req}, 32'd1);
        chk("first_addr", mem.if_mem_addr, 32'h0);
        push(32'h0, 32'h4);  tick();
        push(32'h4, 32'h8);  tick();
        push(32'h8, 32'hC);  tick();
        push(32'hC, 32'h10); tick();
        chk("addr_10", mem.if_mem_addr, 32'h10);

        // Stall coincident with ready at 0x10, held for three edges
        stall = 1'b1;
        push(32'hC, 32'h10); tick();
        chk("hold_req", {31'd0, mem.if_mem_req}, 32'd0);
        push(32'hC, 32'h10); tick();
        push(32'hC, 32'h10); tick();
        chk("hold_req2", {31'd0, mem.if_mem_req}, 32'd0);
        stall = 1'b0;
        push(32'h10, 32'h14); tick();
        chk("release_req", {31'd0, mem.if_mem_req}, 32'd1);
        chk("release_addr", mem.if_mem_addr, 32'h14);

        // Two-cycle latency memory: bubbles between fetches
        zl = 1'b0; rdy = 1'b0;
        push(NOP, 32'h14); tick();
        push(NOP, 32'h14); tick();
        chk("wait_addr", mem.if_mem_addr, 32'h14);
        rdy = 1'b1;
        push(32'h14, 32'h18); tick();
        rdy = 1'b0;
        push(NOP, 32'h18); tick();
        push(NOP, 32'h18); tick();
        chk("wait_addr2", mem.if_mem_addr, 32'h18);
        rdy = 1'b1;
        push(32'h18, 32'h1C); tick();
        rdy = 1'b0;

        // Register redirect while the response is outstanding
        sel = 1'b1; ptype = 2'b01; rega = 32'h200;
        push(NOP, 32'h1C); tick();
        sel = 1'b0;
        push(NOP, 32'h1C); tick();
        chk("kill_addr", mem.if_mem_addr, 32'h1C);
        rdy = 1'b1;
        push(NOP, 32'h1C); tick();
        chk("redir_reg_addr", mem.if_mem_addr, 32'h200);
        push(32'h200, 32'h204); tick();

        // Index redirect coincident with ready
        sel = 1'b1; ptype = 2'b10; pcidx = 32'h4000;
        push(32'h204, 32'h208); tick();
        chk("redir_idx_addr", mem.if_mem_addr, 32'h4000);

        // Same kind of redirect while stalled is ignored
        pcidx = 32'h8000; stall = 1'b1;
        push(32'h204, 32'h208); tick();
        chk("stall_redir_req", {31'd0, mem.if_mem_req}, 32'd0);
        sel = 1'b0; stall = 1'b0;
        push(32'h4000, 32'h4004); tick();
        chk("stall_redir_addr", mem.if_mem_addr, 32'h4004);

        // selpctype 11 uses the branch target; land on the top word and wrap
        sel = 1'b1; ptype = 2'b11; pcimd = 32'hFFFF_FFFC; rega = 32'h300; pcidx = 32'h500;
        push(32'h4004, 32'h4008); tick();
        chk("sel11_addr", mem.if_mem_addr, 32'hFFFF_FFFC);
        sel = 1'b0;
        push(32'hFFFF_FFFC, 32'h0); tick();
        chk("wrap_addr", mem.if_mem_addr, 32'h0);

        // Latest redirect in S_KILL wins
        rdy = 1'b0; sel = 1'b1; ptype = 2'b00; pcimd = 32'h40;
        push(NOP, 32'h0); tick();
        ptype = 2'b01; rega = 32'h80;
        push(NOP, 32'h0); tick();
        sel = 1'b0; rdy = 1'b1;
        push(NOP, 32'h0); tick();
        chk("kill_latest_addr", mem.if_mem_addr, 32'h80);

        // Reset while in S_KILL
        rdy = 1'b0; sel = 1'b1; ptype = 2'b10; pcidx = 32'h100;
        push(NOP, 32'h0); tick();
        sel = 1'b0; reset = 1'b0;
        push(NOP, 32'h0); tick();
        chk("midrst_req", {31'd0, mem.if_mem_req}, 32'd0);
        chk("midrst_addr", mem.if_mem_addr, 32'h0);
        reset = 1'b1; rdy = 1'b1;
        push(NOP, 32'h0); tick();
        chk("postrst_req", {31'd0, mem.if_mem_req}, 32'd1);
        chk("postrst_addr", mem.if_mem_addr, 32'h0);
        push(32'h0, 32'h4); tick();
        chk("postrst_next", mem.if_mem_addr, 32'h4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
